pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Instruction-fetch stage of the MIPS pipeline.
- Holds the program counter and produces PC+4 for the next-PC mux, `mux_pc`.
- Registers the selected next PC returned by `mux_pc` and drives the instruction-memory address.
- Captures fetched instructions into the IF/ID pipeline register, honouring hazard stalls, control-flow flushes, debug-unit enable and HALT detection.

Parameters:
- SIZE_ADDR_PC, 32, PC and address width.
- SIZE_INSTR, 32, instruction width.
- PC_STEP, 4, PC increment in bytes.
- RESET_PC, 0, PC value after reset.
- HALT_OPCODE, 32'hFFFFFFFF, instruction encoding that stops fetch.
- NOP_INSTR, 32'h00000000, bubble inserted on flush.
- SIZE_CYCLES, 32, cycle counter width.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  debug-unit run/step enable; 0 freezes all state.
- i_stall  in  1  hazard-unit stall; holds PC and IF/ID.
- i_flush  in  1  branch/jump/JALR taken; squashes the instruction being fetched.
- i_next_pc  in  SIZE_ADDR_PC  next PC from `mux_pc` `o_pc`.
- i_instruction  in  SIZE_INSTR  instruction memory read data at `o_pc` (combinational read).
- o_pc  out  SIZE_ADDR_PC  current PC / instruction memory address.
- o_suma_pc4  out  SIZE_ADDR_PC  `o_pc` + PC_STEP, combinational; feeds `mux_pc` `i_suma_pc4`.
- o_ifid_pc4  out  SIZE_ADDR_PC  registered PC+4 of the instruction in IF/ID.
- o_ifid_instruction  out  SIZE_INSTR  registered instruction in IF/ID.
- o_ifid_valid  out  1  IF/ID holds a real (non-bubble) instruction.
- o_halted  out  1  HALT has been fetched; fetch stopped.
- o_cycle_count  out  SIZE_CYCLES  cycles executed, for the debug unit.

Behaviour:
- Reset (i_reset=1 at edge) has highest priority and applies regardless of i_enable:
  - o_pc=RESET_PC, o_ifid_pc4=0, o_ifid_instruction=NOP_INSTR, o_ifid_valid=0.
  - o_halted=0, o_cycle_count=0, FSM=RUN.
  - A reset mid-stall, mid-flush or while halted returns the block to this state on the next edge.
- FSM has two states, RUN and HALT.
  - RUN->HALT: on an advancing edge where i_instruction==HALT_OPCODE and i_flush=0.
  - HALT exits only via reset.
- An edge advances when i_enable=1, state=RUN, i_stall=0.
- Update priority each edge when i_enable=1 and state=RUN:
  1. i_flush=1, whether or not i_stall is set:
     - o_pc<=i_next_pc.
     - IF/ID<={NOP_INSTR, valid=0}.
     - HALT detection is suppressed (wrong-path instruction).
  2. Else if i_stall=1: o_pc and IF/ID hold.
  3. Else (advance):
     - o_pc<=i_next_pc.
     - o_ifid_pc4<=o_suma_pc4, o_ifid_instruction<=i_instruction, o_ifid_valid<=1.
     - If i_instruction==HALT_OPCODE: o_pc holds instead of loading i_next_pc, FSM<=HALT, and the HALT word is still captured into IF/ID so it drains down the pipeline.
- State HALT:
  - o_pc holds.
  - IF/ID<={NOP_INSTR, valid=0} from the edge after entry.
  - o_halted=1 (Moore output of the FSM).
  - i_stall and i_flush are ignored.
- i_enable=0: every register holds, including the counter. Single-step means i_enable asserted for exactly one cycle and equals exactly one edge of the rules above.
- o_cycle_count increments by 1 on every edge with i_enable=1 and state=RUN, including stall and flush edges. It wraps modulo 2^SIZE_CYCLES.
- o_suma_pc4 = o_pc + PC_STEP, truncated to SIZE_ADDR_PC bits; 32'hFFFFFFFC wraps to 0.
- No alignment check on i_next_pc; misaligned values are loaded as-is.
- Latency:
  - Next PC is visible on o_pc one edge after presentation.
  - The instruction reaches IF/ID on the same edge its PC is replaced.

Decomposition:
- Shared package `mips_pkg` holds SIZE_ADDR_PC, SIZE_INSTR, PC_STEP, HALT_OPCODE, NOP_INSTR and the RUN/HALT state encoding, shared with decode and the debug unit.
- One sub-module, `if_id_register`: IF/ID pipeline register with hold and flush-to-bubble inputs. It is reused as the pattern for later pipeline registers.
- PC register, adder, FSM and counter stay in `pc_fetch_unit`.

Test Plan:
- Reset then i_enable=1, no stall/flush, bench ties i_next_pc=o_suma_pc4, memory returns 32'h20010005 at 0 and 32'h20020007 at 4:
  - After reset: o_pc=0, o_suma_pc4=4, o_ifid_valid=0.
  - Edge 1: o_pc=4, o_ifid_instruction=32'h20010005, o_ifid_pc4=4, o_ifid_valid=1.
  - Edge 2: o_pc=8, o_ifid_pc4=8.
- i_stall=1 for 3 cycles at o_pc=8 -> o_pc stays 8, IF/ID unchanged, o_cycle_count advances by 3.
- i_flush=1 with i_next_pc=32'h40 at o_pc=12 -> o_pc=32'h40, o_ifid_instruction=0, o_ifid_valid=0. With i_stall=1 simultaneously, the result is identical.
- Memory returns 32'hFFFFFFFF at o_pc=16:
  - Edge: o_ifid_instruction=32'hFFFFFFFF, o_halted=1, o_pc=16.
  - Next edge: o_ifid_valid=0.
  - Stall/flush toggling afterwards changes nothing.
  - i_reset=1 then gives o_pc=0, o_halted=0.
- HALT word presented together with i_flush=1 -> no halt, o_pc=i_next_pc, bubble in IF/ID.
- i_enable=0 for 5 cycles, then a single 1-cycle pulse, starting at o_pc=8 -> o_pc=8 and counter constant during the freeze. After the pulse: o_pc=12, counter +1.
- Force o_pc=32'hFFFFFFFC via flush -> o_suma_pc4=0; advancing gives o_pc=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
// Holds datapath widths, the PC increment, the special HALT and bubble
// encodings and the fetch FSM state encoding. Decode and the debug unit
// import the same package so every stage agrees on these values.
package mips_pkg;

    localparam int SIZE_ADDR_PC = 32;
    localparam int SIZE_INSTR   = 32;
    localparam int PC_STEP      = 4;

    localparam logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register.
// Ports:
//   i_clk, i_reset       clock and synchronous active-high reset
//   i_hold               keep the current contents
//   i_flush              load a bubble (NOP, invalid); wins over i_hold
//   i_pc4, i_instruction PC+4 and instruction entering the register
//   o_pc4, o_instruction registered PC+4 and instruction
//   o_valid              register holds a real instruction, not a bubble
// Later pipeline registers follow the same hold / flush-to-bubble pattern.
module if_id_register
    import mips_pkg::*;
#(
    parameter int                    SIZE_ADDR_PC = mips_pkg::SIZE_ADDR_PC,
    parameter int                    SIZE_INSTR   = mips_pkg::SIZE_INSTR,
    parameter logic [SIZE_INSTR-1:0] NOP_INSTR    = mips_pkg::NOP_INSTR
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_hold,
    input  logic                    i_flush,
    input  logic [SIZE_ADDR_PC-1:0] i_pc4,
    input  logic [SIZE_INSTR-1:0]   i_instruction,
    output logic [SIZE_ADDR_PC-1:0] o_pc4,
    output logic [SIZE_INSTR-1:0]   o_instruction,
    output logic                    o_valid
);

    // A bubble only replaces the instruction and the valid bit; the PC+4
    // field is left untouched because nothing downstream uses it while
    // o_valid is low.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_pc4         <= '0;
            o_instruction <= NOP_INSTR;
            o_valid       <= 1'b0;
        end else if (i_flush) begin
            o_instruction <= NOP_INSTR;
            o_valid       <= 1'b0;
        end else if (!i_hold) begin
            o_pc4         <= i_pc4;
            o_instruction <= i_instruction;
            o_valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage of the MIPS pipeline.
// Ports:
//   i_clk, i_reset      clock and synchronous active-high reset
//   i_enable            debug-unit run/step enable; low freezes everything
//   i_stall             hazard stall; holds PC and IF/ID
//   i_flush             taken control flow; squashes the fetched instruction
//   i_next_pc           next PC selected by mux_pc
//   i_instruction       instruction memory data at o_pc
//   o_pc                current PC / instruction memory address
//   o_suma_pc4          o_pc + PC_STEP, fed back to mux_pc
//   o_ifid_pc4          PC+4 of the instruction held in IF/ID
//   o_ifid_instruction  instruction held in IF/ID
//   o_ifid_valid        IF/ID holds a real instruction
//   o_halted            HALT fetched, fetch stopped until reset
//   o_cycle_count       executed cycles, for the debug unit
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter int                      SIZE_ADDR_PC = mips_pkg::SIZE_ADDR_PC,
    parameter int                      SIZE_INSTR   = mips_pkg::SIZE_INSTR,
    parameter logic [SIZE_ADDR_PC-1:0] PC_STEP      = SIZE_ADDR_PC'(mips_pkg::PC_STEP),
    parameter logic [SIZE_ADDR_PC-1:0] RESET_PC     = '0,
    parameter logic [SIZE_INSTR-1:0]   HALT_OPCODE  = mips_pkg::HALT_OPCODE,
    parameter logic [SIZE_INSTR-1:0]   NOP_INSTR    = mips_pkg::NOP_INSTR,
    parameter int                      SIZE_CYCLES  = 32
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic                    i_stall,
    input  logic                    i_flush,
    input  logic [SIZE_ADDR_PC-1:0] i_next_pc,
    input  logic [SIZE_INSTR-1:0]   i_instruction,
    output logic [SIZE_ADDR_PC-1:0] o_pc,
    output logic [SIZE_ADDR_PC-1:0] o_suma_pc4,
    output logic [SIZE_ADDR_PC-1:0] o_ifid_pc4,
    output logic [SIZE_INSTR-1:0]   o_ifid_instruction,
    output logic                    o_ifid_valid,
    output logic                    o_halted,
    output logic [SIZE_CYCLES-1:0]  o_cycle_count
);

    fetch_state_e            state;
    fetch_state_e            state_next;
    logic [SIZE_ADDR_PC-1:0] pc_next;
    logic                    count_en;
    logic                    ifid_hold;
    logic                    ifid_flush;

    assign o_suma_pc4 = o_pc + PC_STEP;
    assign o_halted   = (state == FETCH_HALT);

    // Next-state and control decode. Flush outranks stall, and a HALT word
    // on the wrong path (flush set) must not stop fetch. A real HALT keeps
    // the PC pointing at itself while the word still drains into IF/ID.
    // Once halted, IF/ID is bubbled every enabled edge and stall/flush are
    // ignored.
    always_comb begin
        state_next = state;
        pc_next    = o_pc;
        count_en   = 1'b0;
        ifid_hold  = 1'b1;
        ifid_flush = 1'b0;
        if (i_enable) begin
            case (state)
                FETCH_RUN: begin
                    count_en = 1'b1;
                    if (i_flush) begin
                        pc_next    = i_next_pc;
                        ifid_flush = 1'b1;
                    end else if (!i_stall) begin
                        ifid_hold = 1'b0;
                        if (i_instruction == HALT_OPCODE) begin
                            state_next = FETCH_HALT;
                        end else begin
                            pc_next = i_next_pc;
                        end
                    end
                end
                FETCH_HALT: begin
                    ifid_flush = 1'b1;
                end
                default: begin
                    state_next = FETCH_RUN;
                end
            endcase
        end
    end

    // PC, FSM state and cycle counter. Reset wins regardless of enable.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= FETCH_RUN;
            o_pc          <= RESET_PC;
            o_cycle_count <= '0;
        end else begin
            state <= state_next;
            o_pc  <= pc_next;
            if (count_en) begin
                o_cycle_count <= o_cycle_count + SIZE_CYCLES'(1);
            end
        end
    end

    if_id_register #(
        .SIZE_ADDR_PC (SIZE_ADDR_PC),
        .SIZE_INSTR   (SIZE_INSTR),
        .NOP_INSTR    (NOP_INSTR)
    ) u_if_id (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_hold        (ifid_hold),
        .i_flush       (ifid_flush),
        .i_pc4         (o_suma_pc4),
        .i_instruction (i_instruction),
        .o_pc4         (o_ifid_pc4),
        .o_instruction (o_ifid_instruction),
        .o_valid       (o_ifid_valid)
    );

endmodule
